// File: rtl/out_stream_packer.sv
// out_stream_packer: packs 64-bit words into 512-bit blocks and writes them as address+data bursts.
// Define OUT_STREAM_PACKER_STALL_CNT_EN to add the stallCycles output counter.
module out_stream_packer #(
  parameter int          BURST_BLOCKS = 16,
  parameter logic [15:0] ID_BASE      = 16'd0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [63:0]  baseAddr,
  input  logic [63:0]  inWord,
  input  logic         inValid,
  input  logic         inLast,
  output logic         inReady,
  output logic [63:0]  outputMemAddr,
  output logic         outputMemAddrValid,
  output logic [7:0]   outputMemAddrLen,
  output logic [15:0]  outputMemAddrId,
  input  logic         outputMemAddrReady,
  output logic [511:0] outputMemBlock,
  output logic         outputMemBlockValid,
  output logic         outputMemBlockLast,
  input  logic         outputMemBlockReady,
  output logic         done,
  output logic [31:0]  wordsWritten
`ifdef OUT_STREAM_PACKER_STALL_CNT_EN
  ,
  output logic [31:0]  stallCycles
`endif
);
  localparam int BW = $clog2(BURST_BLOCKS) + 1;
  localparam int IW = $clog2(BURST_BLOCKS) + 3;
  localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_ADDR = 3'd2, S_DATA = 3'd3, S_DONE = 3'd4;
  logic [2:0]    r_state;
  logic [63:0]   r_addr;
  logic [BW-1:0] r_blk, r_nblk, r_dblk;
  logic [2:0]    r_widx, r_pad;
  logic [15:0]   r_burst;
  logic          r_flush;
  logic [31:0]   r_words;
  logic [63:0]   r_buf [BURST_BLOCKS*8];
  logic          w_start, w_acc, w_full, w_dlast, w_addr_hs, w_data_hs;
  logic [2:0]    w_widx_n;
  logic [BW-1:0] w_blk_n;
  logic [IW-1:0] w_wi;
  assign w_start   = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_acc     = r_state == S_FILL && inValid;
  assign w_widx_n  = r_widx + 3'd1;
  assign w_blk_n   = r_blk + BW'(r_widx == 3'd7);
  assign w_full    = w_blk_n == BW'(BURST_BLOCKS);
  assign w_dlast   = r_dblk == r_nblk - BW'(1);
  assign w_addr_hs = r_state == S_ADDR && outputMemAddrReady;
  assign w_data_hs = r_state == S_DATA && outputMemBlockReady;
  assign w_wi      = IW'({r_blk, r_widx});
  assign inReady             = r_state == S_FILL;
  assign outputMemAddrValid  = r_state == S_ADDR;
  assign outputMemAddr       = outputMemAddrValid ? r_addr : '0;
  assign outputMemAddrLen    = outputMemAddrValid ? 8'(r_nblk - BW'(1)) : '0;
  assign outputMemAddrId     = outputMemAddrValid ? ID_BASE + r_burst : '0;
  assign outputMemBlockValid = r_state == S_DATA;
  assign outputMemBlockLast  = outputMemBlockValid && w_dlast;
  assign done                = r_state == S_DONE;
  assign wordsWritten        = r_words;
  // r_pad is the fill count of the final block (0 = full); slots at or above it read as zero
  for (genvar k = 0; k < 8; k++) begin : g_word
    logic [IW-1:0] w_ri;
    assign w_ri = IW'({r_dblk, 3'(k)});
    assign outputMemBlock[64*k +: 64] =
      (outputMemBlockValid && !(w_dlast && r_pad != 3'd0 && 3'(k) >= r_pad)) ? r_buf[w_ri] : '0;
  end
  always_ff @(posedge clock)
    if (w_acc) r_buf[w_wi] <= inWord;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_blk   <= '0;
      r_widx  <= '0;
      r_nblk  <= '0;
      r_pad   <= '0;
      r_dblk  <= '0;
      r_burst <= '0;
      r_flush <= 1'b0;
      r_words <= '0;
    end else if (w_start) begin
      r_state <= S_FILL;
      r_addr  <= baseAddr;
      r_words <= '0;
      r_burst <= '0;
      r_blk   <= '0;
      r_widx  <= '0;
      r_flush <= 1'b0;
    end else if (w_acc) begin
      r_blk   <= w_blk_n;
      r_widx  <= w_widx_n;
      r_words <= r_words + 32'(r_words != '1);
      if (inLast || w_full) begin
        r_state <= S_ADDR;
        r_flush <= inLast;
        r_nblk  <= w_blk_n + BW'(w_widx_n != 3'd0);
        r_pad   <= w_widx_n;
      end
    end else if (w_addr_hs) begin
      r_state <= S_DATA;
      r_dblk  <= '0;
    end else if (w_data_hs) begin
      if (w_dlast) begin
        r_addr  <= r_addr + 64'({r_nblk, 6'd0});
        r_burst <= r_burst + 16'd1;
        r_blk   <= '0;
        r_widx  <= '0;
        r_state <= r_flush ? S_DONE : S_FILL;
      end else
        r_dblk <= r_dblk + BW'(1);
    end
`ifdef OUT_STREAM_PACKER_STALL_CNT_EN
  logic [31:0] r_stall;
  always_ff @(posedge clock or posedge reset)
    if (reset) r_stall <= '0;
    else if (w_start) r_stall <= '0;
    else if (((outputMemAddrValid && !outputMemAddrReady) ||
              (outputMemBlockValid && !outputMemBlockReady)) && r_stall != '1)
      r_stall <= r_stall + 32'd1;
  assign stallCycles = r_stall;
`endif
endmodule

// File: tb/tb_out_stream_packer.sv
// tb_out_stream_packer: scoreboard bench for out_stream_packer with BURST_BLOCKS=4.
// Define OUT_STREAM_PACKER_STALL_CNT_EN to also check stallCycles.
module tb_out_stream_packer;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [63:0] baseAddr = '0, inWord = '0;
  logic inValid = 1'b0, inLast = 1'b0, ar = 1'b1, br = 1'b1;
  logic inReady, oav, obv, olast, done;
  logic [63:0] oaddr;
  logic [7:0] olen;
  logic [15:0] oid;
  logic [511:0] oblk;
  logic [31:0] words;
`ifdef OUT_STREAM_PACKER_STALL_CNT_EN
  logic [31:0] stalls;
`endif
  out_stream_packer #(.BURST_BLOCKS(4), .ID_BASE(16'd0)) dut (
    .clock(clock), .reset(reset), .start(start), .baseAddr(baseAddr),
    .inWord(inWord), .inValid(inValid), .inLast(inLast), .inReady(inReady),
    .outputMemAddr(oaddr), .outputMemAddrValid(oav), .outputMemAddrLen(olen),
    .outputMemAddrId(oid), .outputMemAddrReady(ar),
    .outputMemBlock(oblk), .outputMemBlockValid(obv), .outputMemBlockLast(olast),
    .outputMemBlockReady(br), .done(done), .wordsWritten(words)
`ifdef OUT_STREAM_PACKER_STALL_CNT_EN
    , .stallCycles(stalls)
`endif
  );
  always #5 clock = ~clock;
  int total = 0, bad = 0, ra = 0, rb = 0, viol = 0, mstall = 0;
  logic [87:0] exp_a[$], obs_a[$];
  logic [512:0] exp_b[$], obs_b[$];
  logic [87:0] w_a, pa = '0;
  logic [512:0] w_b, pb = '0;
  logic pav = 1'b0, par = 1'b0, pbv = 1'b0, pbr = 1'b0;
  assign w_a = {oaddr, olen, oid};
  assign w_b = {olast, oblk};
  // records handshakes, flags unstable/dropped valids, overlap and inReady during output phases
  always @(negedge clock)
    if (reset) begin
      pav <= 1'b0;
      pbv <= 1'b0;
    end else begin
      viol <= viol + int'(pav && !par && (!oav || w_a != pa)) + int'(pbv && !pbr && (!obv || w_b != pb))
                   + int'(inReady && (oav || obv)) + int'(oav && obv);
      mstall <= mstall + int'((oav && !ar) || (obv && !br));
      if (oav && ar) obs_a.push_back(w_a);
      if (obv && br) obs_b.push_back(w_b);
      pav <= oav; par <= ar; pa <= w_a;
      pbv <= obv; pbr <= br; pb <= w_b;
    end
  task automatic push_exp(input logic [63:0] base, input int n, input int v0);
    for (int b = 0; b * 32 < n; b++) begin
      int cnt, nb;
      cnt = (n - 32 * b > 32) ? 32 : n - 32 * b;
      nb = (cnt + 7) / 8;
      exp_a.push_back({base + 64'(b * 256), 8'(nb - 1), 16'(b)});
      for (int j = 0; j < nb; j++) begin
        logic [511:0] blk;
        blk = '0;
        for (int k = 0; k < 8; k++)
          if (32 * b + 8 * j + k < n) blk[64*k +: 64] = 64'(v0 + 32 * b + 8 * j + k);
        exp_b.push_back({j == nb - 1, blk});
      end
    end
  endtask
  task automatic do_start(input logic [63:0] b);
    baseAddr = b;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask
  task automatic send_words(input int n, input int v0, input int sp);
    for (int i = 0; i < n; i++) begin
      logic acc;
      int c;
      inWord = 64'(v0 + i);
      inValid = 1'b1;
      inLast = (i == n - 1);
      if (i == sp) begin start = 1'b1; baseAddr = 64'h9000; end
      c = 0;
      do begin
        @(negedge clock) acc = inReady;
        @(posedge clock); #1;
        start = 1'b0;
        c++;
      end while (!acc && c < 500);
    end
    inValid = 1'b0;
    inLast = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clock);
    total++;
    if ({inReady, oav, oaddr, olen, oid, obv, olast, done, words} !== '0) begin
      bad++; $display("FAIL reset_ctl got=%h need=0", {inReady, oav, oaddr, olen, oid, obv, olast, done, words});
    end
    total++;
    if (oblk !== '0) begin bad++; $display("FAIL reset_blk got=%h need=0", oblk); end
    @(posedge clock); #1 reset = 1'b0;
  endtask
  task automatic test_full;
    logic [87:0] ea;
    logic [512:0] eb;
    do_start(64'h1000);
    push_exp(64'h1000, 32, 0);
    send_words(32, 0, -1);
    for (int c = 0; c < 2000 && done !== 1'b1; c++) @(negedge clock);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL full_done got=%b need=1", done); end
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); total++;
      if (ra >= obs_a.size()) begin bad++; $display("FAIL full_addr got=none need=%h", ea); end
      else begin if (obs_a[ra] !== ea) begin bad++; $display("FAIL full_addr got=%h need=%h", obs_a[ra], ea); end ra++; end
    end
    while (exp_b.size() > 0) begin
      eb = exp_b.pop_front(); total++;
      if (rb >= obs_b.size()) begin bad++; $display("FAIL full_blk got=none need=%h", eb); end
      else begin if (obs_b[rb] !== eb) begin bad++; $display("FAIL full_blk got=%h need=%h", obs_b[rb], eb); end rb++; end
    end
    total++;
    if (words !== 32'd32) begin bad++; $display("FAIL full_words got=%0d need=32", words); end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL full_protocol got=%0d need=0", viol); end
  endtask
  task automatic test_two_bursts;
    logic [87:0] ea;
    logic [512:0] eb;
    do_start(64'h1000);
    push_exp(64'h1000, 40, 0);
    send_words(40, 0, -1);
    for (int c = 0; c < 2000 && done !== 1'b1; c++) @(negedge clock);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL two_done got=%b need=1", done); end
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); total++;
      if (ra >= obs_a.size()) begin bad++; $display("FAIL two_addr got=none need=%h", ea); end
      else begin if (obs_a[ra] !== ea) begin bad++; $display("FAIL two_addr got=%h need=%h", obs_a[ra], ea); end ra++; end
    end
    while (exp_b.size() > 0) begin
      eb = exp_b.pop_front(); total++;
      if (rb >= obs_b.size()) begin bad++; $display("FAIL two_blk got=none need=%h", eb); end
      else begin if (obs_b[rb] !== eb) begin bad++; $display("FAIL two_blk got=%h need=%h", obs_b[rb], eb); end rb++; end
    end
    total++;
    if (words !== 32'd40) begin bad++; $display("FAIL two_words got=%0d need=40", words); end
  endtask
  task automatic test_partial;
    logic [87:0] ea;
    logic [512:0] eb;
    for (int p = 0; p < 2; p++) begin
      int n;
      n = p == 0 ? 11 : 16;
      do_start(64'h1000);
      push_exp(64'h1000, n, 7);
      send_words(n, 7, -1);
      for (int c = 0; c < 2000 && done !== 1'b1; c++) @(negedge clock);
      while (exp_a.size() > 0) begin
        ea = exp_a.pop_front(); total++;
        if (ra >= obs_a.size()) begin bad++; $display("FAIL part%0d_addr got=none need=%h", n, ea); end
        else begin if (obs_a[ra] !== ea) begin bad++; $display("FAIL part%0d_addr got=%h need=%h", n, obs_a[ra], ea); end ra++; end
      end
      while (exp_b.size() > 0) begin
        eb = exp_b.pop_front(); total++;
        if (rb >= obs_b.size()) begin bad++; $display("FAIL part%0d_blk got=none need=%h", n, eb); end
        else begin if (obs_b[rb] !== eb) begin bad++; $display("FAIL part%0d_blk got=%h need=%h", n, obs_b[rb], eb); end rb++; end
      end
      total++;
      if (words !== 32'(n)) begin bad++; $display("FAIL part_words got=%0d need=%0d", words, n); end
    end
    total++;
    if (obs_b.size() != rb) begin bad++; $display("FAIL part_extra got=%0d need=%0d", obs_b.size(), rb); end
  endtask
  task automatic test_stall;
    logic [87:0] ea;
    logic [512:0] eb;
    int s0;
    ar = 1'b0;
    br = 1'b0;
    do_start(64'h4000);
    s0 = mstall;
    push_exp(64'h4000, 11, 0);
    send_words(11, 0, -1);
    for (int c = 0; c < 100 && oav !== 1'b1; c++) @(negedge clock);
    repeat (5) @(posedge clock);
    #1 ar = 1'b1;
    for (int c = 0; c < 400 && done !== 1'b1; c++) begin @(posedge clock); #1 br = ~br; end
    ar = 1'b1;
    br = 1'b1;
    @(negedge clock);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b need=1", done); end
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); total++;
      if (ra >= obs_a.size()) begin bad++; $display("FAIL stall_addr got=none need=%h", ea); end
      else begin if (obs_a[ra] !== ea) begin bad++; $display("FAIL stall_addr got=%h need=%h", obs_a[ra], ea); end ra++; end
    end
    while (exp_b.size() > 0) begin
      eb = exp_b.pop_front(); total++;
      if (rb >= obs_b.size()) begin bad++; $display("FAIL stall_blk got=none need=%h", eb); end
      else begin if (obs_b[rb] !== eb) begin bad++; $display("FAIL stall_blk got=%h need=%h", obs_b[rb], eb); end rb++; end
    end
    total++;
    if (obs_b.size() != rb) begin bad++; $display("FAIL stall_extra got=%0d need=%0d", obs_b.size(), rb); end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL stall_protocol got=%0d need=0", viol); end
`ifdef OUT_STREAM_PACKER_STALL_CNT_EN
    total++;
    if (stalls !== 32'(mstall - s0)) begin bad++; $display("FAIL stall_count got=%0d need=%0d", stalls, mstall - s0); end
`endif
  endtask
  task automatic test_reset_mid;
    logic [87:0] ea;
    logic [512:0] eb;
    ar = 1'b1;
    br = 1'b0;
    do_start(64'h7000);
    send_words(32, 0, -1);
    for (int c = 0; c < 100 && obv !== 1'b1; c++) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({inReady, oav, oaddr, olen, oid, obv, olast, done, words} !== '0) begin
      bad++; $display("FAIL midreset_ctl got=%h need=0", {inReady, oav, oaddr, olen, oid, obv, olast, done, words});
    end
    total++;
    if (oblk !== '0) begin bad++; $display("FAIL midreset_blk got=%h need=0", oblk); end
    @(negedge clock); #1 reset = 1'b0;
    br = 1'b1;
    ra = obs_a.size();
    rb = obs_b.size();
    do_start(64'h2000);
    push_exp(64'h2000, 8, 100);
    send_words(8, 100, -1);
    for (int c = 0; c < 2000 && done !== 1'b1; c++) @(negedge clock);
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); total++;
      if (ra >= obs_a.size()) begin bad++; $display("FAIL after_reset_addr got=none need=%h", ea); end
      else begin if (obs_a[ra] !== ea) begin bad++; $display("FAIL after_reset_addr got=%h need=%h", obs_a[ra], ea); end ra++; end
    end
    while (exp_b.size() > 0) begin
      eb = exp_b.pop_front(); total++;
      if (rb >= obs_b.size()) begin bad++; $display("FAIL after_reset_blk got=none need=%h", eb); end
      else begin if (obs_b[rb] !== eb) begin bad++; $display("FAIL after_reset_blk got=%h need=%h", obs_b[rb], eb); end rb++; end
    end
  endtask
  task automatic test_start_ignored;
    logic [87:0] ea;
    logic [512:0] eb;
    do_start(64'h5000);
    push_exp(64'h5000, 10, 50);
    send_words(10, 50, 4);
    for (int c = 0; c < 2000 && done !== 1'b1; c++) @(negedge clock);
    total++;
    if (words !== 32'd10) begin bad++; $display("FAIL ignore_words got=%0d need=10", words); end
    do_start(64'h3000);
    total++;
    if ({done, words} !== 33'd0) begin bad++; $display("FAIL restart_clear got=%h need=0", {done, words}); end
    push_exp(64'h3000, 5, 200);
    send_words(5, 200, -1);
    for (int c = 0; c < 2000 && done !== 1'b1; c++) @(negedge clock);
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); total++;
      if (ra >= obs_a.size()) begin bad++; $display("FAIL restart_addr got=none need=%h", ea); end
      else begin if (obs_a[ra] !== ea) begin bad++; $display("FAIL restart_addr got=%h need=%h", obs_a[ra], ea); end ra++; end
    end
    while (exp_b.size() > 0) begin
      eb = exp_b.pop_front(); total++;
      if (rb >= obs_b.size()) begin bad++; $display("FAIL restart_blk got=none need=%h", eb); end
      else begin if (obs_b[rb] !== eb) begin bad++; $display("FAIL restart_blk got=%h need=%h", obs_b[rb], eb); end rb++; end
    end
    total++;
    if (words !== 32'd5) begin bad++; $display("FAIL restart_words got=%0d need=5", words); end
    total++;
    if (obs_a.size() != ra) begin bad++; $display("FAIL restart_extra got=%0d need=%0d", obs_a.size(), ra); end
  endtask
  initial begin
    test_reset;
    test_full;
    test_two_bursts;
    test_partial;
    test_stall;
    test_reset_mid;
    test_start_ignored;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
